// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its instruction memory / decode datapath.
// Memory handshake: IMEM_READ requests IMEM_ADDRESS, and a word is taken on any edge where IMEM_READ=1 and IMEM_BUSYWAIT=0.
// Issue handshake: the instruction retires on any edge where INSTR_VALID=1 and CPU_STALL=0.
interface fetch_sequencer_if;
    logic [31:0] PC;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic        CPU_STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        FETCH_FAULT;
    logic [15:0] RETIRE_COUNT;

    modport master (
        output PC, IMEM_READ, IMEM_ADDRESS, INSTRUCTION, INSTR_VALID,
               FETCH_FAULT, RETIRE_COUNT,
        input  IMEM_READDATA, IMEM_BUSYWAIT, CPU_STALL, BRANCH_TAKEN, BRANCH_TARGET
    );

    modport slave (
        input  PC, IMEM_READ, IMEM_ADDRESS, INSTRUCTION, INSTR_VALID,
               FETCH_FAULT, RETIRE_COUNT,
        output IMEM_READDATA, IMEM_BUSYWAIT, CPU_STALL, BRANCH_TAKEN, BRANCH_TARGET
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/issue controller: owns the PC, fetches through a BUSYWAIT
// memory, holds one instruction for the datapath and advances on retire.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic               CLK,
    input  logic               RESET,
    fetch_sequencer_if.master  bus,
    output logic [1:0]         state_o
);

    localparam logic [31:0] STEP        = 32'(PC_STEP);
    localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        FAULT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        read_q, read_d;
    logic        fault_q, fault_d;
    logic [15:0] retire_q, retire_d;
    logic [7:0]  wait_q, wait_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            valid_q  <= 1'b0;
            read_q   <= 1'b0;
            fault_q  <= 1'b0;
            retire_q <= 16'h0;
            wait_q   <= 8'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            read_q   <= read_d;
            fault_q  <= fault_d;
            retire_q <= retire_d;
            wait_q   <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        read_d   = read_q;
        fault_d  = fault_q;
        retire_d = retire_q;
        wait_d   = wait_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                read_d  = 1'b1;
            end
            FETCH: begin
                if (!bus.IMEM_BUSYWAIT) begin
                    instr_d = bus.IMEM_READDATA;
                    read_d  = 1'b0;
                    valid_d = 1'b1;
                    wait_d  = 8'h0;
                    state_d = ISSUE;
                end else if (wait_q == TIMEOUT_CNT) begin
                    // Counter is left as-is so it cannot wrap past TIMEOUT=255.
                    fault_d = 1'b1;
                    read_d  = 1'b0;
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ISSUE: begin
                // Branch inputs only matter on the retiring edge.
                if (!bus.CPU_STALL) begin
                    retire_d = retire_q + 16'd1;
                    valid_d  = 1'b0;
                    read_d   = 1'b1;
                    state_d  = FETCH;
                    pc_d     = bus.BRANCH_TAKEN ? {bus.BRANCH_TARGET[31:2], 2'b00}
                                                : pc_q + STEP;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.PC           = pc_q;
        bus.IMEM_ADDRESS = pc_q;
        bus.IMEM_READ    = read_q;
        bus.INSTRUCTION  = instr_q;
        bus.INSTR_VALID  = valid_q;
        bus.FETCH_FAULT  = fault_q;
        bus.RETIRE_COUNT = retire_q;
        state_o          = state_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: zero-wait run, busywait, stall with branch,
// taken branch, timeout fault, asynchronous resets and PC wrap.
module tb_fetch_sequencer;

    logic       clk;
    logic       rst;
    logic [1:0] state;
    int         checks;
    int         errors;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_PC(32'h0), .PC_STEP(4), .TIMEOUT(4)) dut (
        .CLK     (clk),
        .RESET   (rst),
        .bus     (bus.master),
        .state_o (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.IMEM_BUSYWAIT = 1'b0;
        bus.IMEM_READDATA = 32'h0000_0105;
        bus.CPU_STALL     = 1'b0;
        bus.BRANCH_TAKEN  = 1'b0;
        bus.BRANCH_TARGET = 32'h0;

        repeat (2) tick();
        chk("rst_pc", bus.PC, 32'h0);
        chk("rst_addr", bus.IMEM_ADDRESS, 32'h0);
        chk("rst_instr", bus.INSTRUCTION, 32'h0);
        chk("rst_valid", 32'(bus.INSTR_VALID), 32'h0);
        chk("rst_read", 32'(bus.IMEM_READ), 32'h0);
        chk("rst_fault", 32'(bus.FETCH_FAULT), 32'h0);
        chk("rst_retire", 32'(bus.RETIRE_COUNT), 32'h0);
        chk("rst_state", 32'(state), 32'h0);

        // Zero-wait memory, no stalls.
        rst = 1'b0;
        tick();
        chk("idle_exit_state", 32'(state), 32'h1);
        chk("idle_exit_read", 32'(bus.IMEM_READ), 32'h1);
        chk("idle_exit_valid", 32'(bus.INSTR_VALID), 32'h0);
        tick();
        chk("zw_issue0_valid", 32'(bus.INSTR_VALID), 32'h1);
        chk("zw_issue0_read", 32'(bus.IMEM_READ), 32'h0);
        chk("zw_issue0_instr", bus.INSTRUCTION, 32'h0000_0105);
        chk("zw_issue0_pc", bus.PC, 32'h0);
        tick();
        chk("zw_ret1_pc", bus.PC, 32'h4);
        chk("zw_ret1_valid", 32'(bus.INSTR_VALID), 32'h0);
        chk("zw_ret1_read", 32'(bus.IMEM_READ), 32'h1);
        chk("zw_ret1_count", 32'(bus.RETIRE_COUNT), 32'h1);
        tick();
        chk("zw_issue1_valid", 32'(bus.INSTR_VALID), 32'h1);
        tick();
        chk("zw_ret2_pc", bus.PC, 32'h8);
        tick();
        tick();
        chk("zw_ret3_pc", bus.PC, 32'hC);
        chk("zw_ret3_addr", bus.IMEM_ADDRESS, 32'hC);
        chk("zw_ret3_count", 32'(bus.RETIRE_COUNT), 32'h3);

        // Three busywait cycles on the fetch at PC=12.
        bus.IMEM_BUSYWAIT = 1'b1;
        bus.IMEM_READDATA = 32'h0000_0ABC;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bw_read", 32'(bus.IMEM_READ), 32'h1);
            chk("bw_valid", 32'(bus.INSTR_VALID), 32'h0);
            chk("bw_pc", bus.PC, 32'hC);
        end
        bus.IMEM_BUSYWAIT = 1'b0;
        tick();
        chk("bw_done_valid", 32'(bus.INSTR_VALID), 32'h1);
        chk("bw_done_read", 32'(bus.IMEM_READ), 32'h0);
        chk("bw_done_instr", bus.INSTRUCTION, 32'h0000_0ABC);
        tick();
        chk("bw_ret_pc", bus.PC, 32'h10);
        chk("bw_ret_count", 32'(bus.RETIRE_COUNT), 32'h4);

        // Restart, then stall at PC=8 with a branch asserted during the stall.
        rst = 1'b1;
        #2;
        chk("rst2_pc", bus.PC, 32'h0);
        chk("rst2_count", 32'(bus.RETIRE_COUNT), 32'h0);
        tick();
        rst = 1'b0;
        bus.IMEM_READDATA = 32'h0000_0105;
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("st_pre_pc", bus.PC, 32'h8);
        bus.IMEM_READDATA = 32'h0000_0777;
        tick();
        chk("st_issue_instr", bus.INSTRUCTION, 32'h0000_0777);
        chk("st_issue_count", 32'(bus.RETIRE_COUNT), 32'h2);
        bus.CPU_STALL     = 1'b1;
        bus.BRANCH_TAKEN  = 1'b1;
        bus.BRANCH_TARGET = 32'h0000_0043;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("st_instr", bus.INSTRUCTION, 32'h0000_0777);
            chk("st_valid", 32'(bus.INSTR_VALID), 32'h1);
            chk("st_pc", bus.PC, 32'h8);
            chk("st_count", 32'(bus.RETIRE_COUNT), 32'h2);
        end
        bus.CPU_STALL    = 1'b0;
        bus.BRANCH_TAKEN = 1'b0;
        tick();
        chk("st_rel_pc", bus.PC, 32'hC);
        chk("st_rel_count", 32'(bus.RETIRE_COUNT), 32'h3);
        chk("st_rel_valid", 32'(bus.INSTR_VALID), 32'h0);

        // Taken branch on retire at PC=12.
        bus.IMEM_READDATA = 32'h0000_1234;
        tick();
        chk("br_issue_pc", bus.PC, 32'hC);
        bus.BRANCH_TAKEN  = 1'b1;
        bus.BRANCH_TARGET = 32'h0000_0043;
        tick();
        chk("br_pc", bus.PC, 32'h40);
        chk("br_addr", bus.IMEM_ADDRESS, 32'h40);
        chk("br_read", 32'(bus.IMEM_READ), 32'h1);
        chk("br_count", 32'(bus.RETIRE_COUNT), 32'h4);
        bus.BRANCH_TAKEN = 1'b0;

        // BUSYWAIT stuck high with TIMEOUT=4: fault on the fifth waiting edge.
        bus.IMEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_wait_fault", 32'(bus.FETCH_FAULT), 32'h0);
            chk("to_wait_read", 32'(bus.IMEM_READ), 32'h1);
            chk("to_wait_state", 32'(state), 32'h1);
        end
        tick();
        chk("to_fault", 32'(bus.FETCH_FAULT), 32'h1);
        chk("to_read", 32'(bus.IMEM_READ), 32'h0);
        chk("to_valid", 32'(bus.INSTR_VALID), 32'h0);
        chk("to_state", 32'(state), 32'h3);
        bus.IMEM_BUSYWAIT = 1'b0;
        bus.BRANCH_TAKEN  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fz_fault", 32'(bus.FETCH_FAULT), 32'h1);
            chk("fz_pc", bus.PC, 32'h40);
            chk("fz_count", 32'(bus.RETIRE_COUNT), 32'h4);
            chk("fz_instr", bus.INSTRUCTION, 32'h0000_1234);
            chk("fz_state", 32'(state), 32'h3);
        end
        bus.BRANCH_TAKEN = 1'b0;

        // Reset out of FAULT, without a clock edge.
        rst = 1'b1;
        #2;
        chk("fr_fault", 32'(bus.FETCH_FAULT), 32'h0);
        chk("fr_pc", bus.PC, 32'h0);
        chk("fr_count", 32'(bus.RETIRE_COUNT), 32'h0);
        chk("fr_state", 32'(state), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("fr_restart_read", 32'(bus.IMEM_READ), 32'h1);
        chk("fr_restart_addr", bus.IMEM_ADDRESS, 32'h0);

        // Reset mid-FETCH.
        rst = 1'b1;
        #2;
        chk("mf_read", 32'(bus.IMEM_READ), 32'h0);
        chk("mf_state", 32'(state), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("mi_pre_valid", 32'(bus.INSTR_VALID), 32'h1);

        // Reset mid-ISSUE.
        rst = 1'b1;
        #2;
        chk("mi_valid", 32'(bus.INSTR_VALID), 32'h0);
        chk("mi_instr", bus.INSTRUCTION, 32'h0);
        chk("mi_state", 32'(state), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("wr_issue_pc", bus.PC, 32'h0);

        // Unaligned target is forced to a word address, then PC wraps to 0.
        bus.BRANCH_TAKEN  = 1'b1;
        bus.BRANCH_TARGET = 32'hFFFF_FFFF;
        tick();
        chk("wr_top_pc", bus.PC, 32'hFFFF_FFFC);
        chk("wr_top_count", 32'(bus.RETIRE_COUNT), 32'h1);
        bus.BRANCH_TAKEN = 1'b0;
        tick();
        chk("wr_top_valid", 32'(bus.INSTR_VALID), 32'h1);
        tick();
        chk("wr_pc", bus.PC, 32'h0);
        chk("wr_addr", bus.IMEM_ADDRESS, 32'h0);
        chk("wr_count", 32'(bus.RETIRE_COUNT), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
